// File: rtl/serial_subtractor_nbit.sv
// Digit-serial d = a - b - b_in, DIGIT bits per cycle, LSB first; latency WIDTH/DIGIT cycles after accept.
// No backpressure: start is taken in IDLE/DONE only, ignored while busy; results held until the next completion.
module serial_subtractor_nbit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             V,
    output logic             Z
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor_nbit: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic                   brw_q, brw_d, bout_q, bout_d, v_q, v_d, z_q, z_d;
    logic [DIGIT:0]         diff;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                   msb_bin;
    logic                   last;

    always_comb begin
        diff    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
        // Borrow into the chunk MSB recovered from the sum bit: diff = a ^ b ^ borrow_in.
        msb_bin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ diff[DIGIT-1];
        res_cat = {diff[DIGIT-1:0], res_q};
        last    = (cnt_q == CW'(N - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;

        case (state_q)
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = diff[DIGIT];
                res_d = res_cat[WIDTH+DIGIT-1:DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    d_d     = res_cat[WIDTH+DIGIT-1:DIGIT];
                    bout_d  = diff[DIGIT];
                    v_d     = msb_bin ^ diff[DIGIT];
                    z_d     = (res_cat[WIDTH+DIGIT-1:DIGIT] == '0);
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = b_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign d     = d_q;
    assign b_out = bout_q;
    assign V     = v_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Bench for serial_subtractor_nbit: DIGIT=4, 1 and 16 instances share stimulus; each has an
// operation-level reference model compared every cycle, plus directed literal expectations.
module tb_serial_subtractor_nbit;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         b_in  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    always #5 clk = ~clk;

    logic         busy_w [3];
    logic         done_w [3];
    logic         bo_w   [3];
    logic         v_w    [3];
    logic         z_w    [3];
    logic [W-1:0] d_w    [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                                    output logic [W-1:0] rd, output logic rbo,
                                    output logic rv, output logic rz);
        logic [W:0] full;
        int sres;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        rd   = full[W-1:0];
        rbo  = full[W];
        sres = int'($signed(x)) - int'($signed(y)) - int'(bi);
        rv   = (sres < -32768) || (sres > 32767);
        rz   = (rd == '0);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_cfg
            localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
            localparam int NC = W / DG;

            serial_subtractor_nbit #(.WIDTH(W), .DIGIT(DG)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (start),
                .a     (a),
                .b     (b),
                .b_in  (b_in),
                .busy  (busy_w[g]),
                .done  (done_w[g]),
                .d     (d_w[g]),
                .b_out (bo_w[g]),
                .V     (v_w[g]),
                .Z     (z_w[g])
            );

            // Operation-level model: cycles remaining in flight plus the pending arithmetic result.
            int           rem;
            logic [W-1:0] pd, md;
            logic         pbo, pv, pz, mbo, mv, mz, mdone;

            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem = 0; md = '0; mbo = 0; mv = 0; mz = 0; mdone = 0;
                    pd = '0; pbo = 0; pv = 0; pz = 0;
                end else begin
                    mdone = 0;
                    if (rem > 0) begin
                        rem--;
                        if (rem == 0) begin
                            md = pd; mbo = pbo; mv = pv; mz = pz; mdone = 1;
                        end
                    end else if (start) begin
                        ref_sub(a, b, b_in, pd, pbo, pv, pz);
                        rem = NC;
                    end
                end
            end

            always @(negedge clk) begin
                if (chk_en) begin
                    check($sformatf("model busy D%0d", DG), busy_w[g], rem > 0);
                    check($sformatf("model done D%0d", DG), done_w[g], mdone);
                    check($sformatf("model d D%0d", DG), d_w[g], md);
                    check($sformatf("model b_out D%0d", DG), bo_w[g], mbo);
                    check($sformatf("model V D%0d", DG), v_w[g], mv);
                    check($sformatf("model Z D%0d", DG), z_w[g], mz);
                end
            end
        end
    endgenerate

    task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
        @(negedge clk);
        a = aa; b = bb; b_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until the DIGIT=4 instance shows done, scrambling operands meanwhile.
    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done_w[0] && cyc < 40) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
            cyc++;
        end
    endtask

    task automatic check_res(input string name, input int n, input logic [W-1:0] ed,
                             input logic ebo, input logic ev, input logic ez);
        for (int g = 0; g < n; g++) begin
            check($sformatf("%s d cfg%0d", name, g), d_w[g], ed);
            check($sformatf("%s b_out cfg%0d", name, g), bo_w[g], ebo);
            check($sformatf("%s V cfg%0d", name, g), v_w[g], ev);
            check($sformatf("%s Z cfg%0d", name, g), z_w[g], ez);
        end
    endtask

    task automatic run_case(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic bi, input logic [W-1:0] ed, input logic ebo,
                            input logic ev, input logic ez);
        int cyc;
        op(aa, bb, bi);
        check({name, " busy after accept"}, busy_w[0], 1'b1);
        wait_done0(cyc);
        check({name, " latency"}, cyc, 4);
        check_res(name, 1, ed, ebo, ev, ez);
        @(negedge clk);
        check({name, " done one cycle"}, done_w[0], 1'b0);
        repeat (20) @(negedge clk);
        check_res(name, 3, ed, ebo, ev, ez);
    endtask

    initial begin
        int cyc;
        int ndone;

        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset busy cfg%0d", g), busy_w[g], 1'b0);
            check($sformatf("reset done cfg%0d", g), done_w[g], 1'b0);
            check($sformatf("reset d cfg%0d", g), d_w[g], 16'h0000);
            check($sformatf("reset Z cfg%0d", g), z_w[g], 1'b0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_case("c1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
        run_case("c2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_case("c2b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_case("c3", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // start held high through RUN: only one completion for the DIGIT=4 instance
        @(negedge clk);
        a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_w[0]) ndone++;
            @(negedge clk);
        end
        check("busy-start done count", ndone, 1);
        check("busy-start d", d_w[0], 16'h1200);

        // back-to-back: second start on the DONE cycle
        op(16'h0000, 16'h0001, 1'b0);
        wait_done0(cyc);
        a = 16'h8000; b = 16'h0001; b_in = 1'b0; start = 1'b1;
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        while (!done_w[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b done spacing", cyc, 5);
        check("b2b d", d_w[0], 16'h7FFF);
        check("b2b V", v_w[0], 1'b1);
        repeat (20) @(negedge clk);

        // reset mid-RUN
        op(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("midrst busy cfg%0d", g), busy_w[g], 1'b0);
            check($sformatf("midrst d cfg%0d", g), d_w[g], 16'h0000);
            check($sformatf("midrst V cfg%0d", g), v_w[g], 1'b0);
            check($sformatf("midrst b_out cfg%0d", g), bo_w[g], 1'b0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        check("midrst no done", ndone, 0);
        run_case("postrst", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // random traffic, checked cycle by cycle against the models
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            b_in  = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
